grain_keystream_gen: RTL and testbench
======================================

Name: grain_keystream_gen

Overview:
- Parametrised successor to the team's reduced Grain generator: one LFSR (L_W bits) and one NFSR (N_W bits), with tap sets given as parameters.
- Adds a Grain-style initialisation phase (INIT_ROUNDS clocks with the output bit fed back, optionally skipped).
- Packs keystream bits into OUT_W-bit words behind a valid/ready handshake, and stalls cleanly under back-pressure.
- Sits between the seed/key register file and the stream-cipher XOR datapath.

Parameters:
- L_W, 80, LFSR width.
- N_W, 24, NFSR width.
- LF_MASK, bits {0,13,23,38,51,62} set, LFSR feedback taps (L_W bits).
- NF_MASK, bits {0,5,9,14,20} set, NFSR linear feedback taps (N_W bits).
- NA, 3, NFSR index of the first NFSR AND-term operand.
- NB, 17, NFSR index of the second NFSR AND-term operand.
- ZL_MASK, bits {0,25,64} set, LFSR output taps.
- ZN_MASK, bits {1,10,22} set, NFSR output taps.
- ZA, 46, LFSR index of the output AND term.
- ZB, 12, NFSR index of the output AND term.
- INIT_ROUNDS, 160, number of initialisation clocks (must be ≥1).
- OUT_W, 8, output word width (must be ≥1).

Ports:
- Clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to load seeds and begin.
- skip_init  in  1  sampled with start; 1 = go straight to RUN.
- SEED_l  in  L_W  LFSR seed.
- SEED_n  in  N_W  NFSR seed.
- busy  out  1  high in INIT.
- running  out  1  high in RUN.
- ks_bit  out  1  keystream bit produced this step.
- ks_bit_valid  out  1  ks_bit valid (RUN step taken).
- out_word  out  OUT_W  packed keystream word.
- out_valid  out  1  word available.
- out_ready  in  1  consumer accepts word.

Behaviour:
- Step function (combinational on registered state L, N):
  - z = ^(L&ZL_MASK) ^ ^(N&ZN_MASK) ^ (L[ZA]&N[ZB])
  - lf = ^(L&LF_MASK)
  - nf = ^(N&NF_MASK) ^ L[0] ^ (N[NA]&N[NB])
  - In INIT: lf ^= z and nf ^= z.
  - A step does L <= {lf, L[L_W-1:1]} and N <= {nf, N[N_W-1:1]}.
- Reset (reset==0, asynchronous): state IDLE; L, N, round counter, bit counter and collector are 0; every output is 0.
- IDLE: no stepping. On start: L<=SEED_l, N<=SEED_n, bit_cnt<=0. Next state is RUN if skip_init, else INIT with rnd<=INIT_ROUNDS-1.
- INIT: one step per cycle, busy=1, no keystream emitted. At rnd==0, take the last step and go to RUN. busy is high for exactly INIT_ROUNDS cycles.
- RUN:
  - Stall condition: out_valid && !out_ready && bit_cnt==OUT_W-1.
  - If not stalled: take a step, ks_bit=z, ks_bit_valid=1, and shift z into the collector MSB-first (the first bit of the word lands in out_word[OUT_W-1]).
  - When bit_cnt==OUT_W-1 and a step is taken: out_word<=completed word, out_valid<=1 next cycle, bit_cnt<=0.
  - While stalled: L, N, collector and bit_cnt freeze; ks_bit_valid=0.
- Handshake:
  - out_valid stays high and out_word stays stable until out_valid&&out_ready.
  - A transfer clears out_valid, unless a new word completes in the same cycle, in which case out_valid stays 1 with the new word.
  - Sustained throughput is 1 bit per cycle with out_ready=1.
- start during INIT or RUN: aborts and reloads exactly as from IDLE. Pending out_valid is dropped (0) and the partial word is discarded.
- start and the reset assertion coincide: reset wins.
- No transition returns to IDLE except reset.
- All-zero seeds are a fixed point: z is 0 forever, in both INIT and RUN.

Test Plan:
1. Reset mid-RUN with out_valid=1 → all outputs 0 asynchronously, before the next edge; IDLE holds with start=0.
2. start, skip_init=0, zero seeds, out_ready=1 → busy high exactly 160 cycles, then running=1. Every ks_bit is 0; out_valid first rises 8 cycles after RUN entry; out_word=8'h00.
3. start, skip_init=1, SEED_l=80'h1, SEED_n=0 → first ks_bit=1, so the first out_word has MSB=1. The full word stream must match the bit-serial golden model for 64 words.
4. Back-pressure: out_ready held 0 for 20 cycles after the first out_valid → the generator freezes after 7 more bits. out_word is unchanged; when ready is released the stream continues with no bit lost or duplicated (compared against the golden model).
5. start pulse during INIT at round 50 with new seeds 80'h114313ecba9118200465/24'h313ec8 → INIT restarts with a full 160 cycles; output equals a clean run from those seeds.
6. Re-parametrise L_W=32, N_W=16, OUT_W=4, INIT_ROUNDS=1, SEED_l=80'h123456789ABCDEF12345[31:0], SEED_n=24'h9a172d[15:0] → busy for 1 cycle; words match the golden model.

Source files
------------

// File: rtl/grain_keystream_gen.sv
// Grain-style keystream generator: one LFSR and one NFSR with parameterised taps,
// an optional initialisation phase, and MSB-first packing into OUT_W-bit words.
module grain_keystream_gen #(
    parameter int              L_W         = 80,
    parameter int              N_W         = 24,
    parameter logic [L_W-1:0]  LF_MASK     = (80'd1 << 0) | (80'd1 << 13) | (80'd1 << 23) |
                                             (80'd1 << 38) | (80'd1 << 51) | (80'd1 << 62),
    parameter logic [N_W-1:0]  NF_MASK     = (24'd1 << 0) | (24'd1 << 5) | (24'd1 << 9) |
                                             (24'd1 << 14) | (24'd1 << 20),
    parameter int              NA          = 3,
    parameter int              NB          = 17,
    parameter logic [L_W-1:0]  ZL_MASK     = (80'd1 << 0) | (80'd1 << 25) | (80'd1 << 64),
    parameter logic [N_W-1:0]  ZN_MASK     = (24'd1 << 1) | (24'd1 << 10) | (24'd1 << 22),
    parameter int              ZA          = 46,
    parameter int              ZB          = 12,
    parameter int              INIT_ROUNDS = 160,
    parameter int              OUT_W       = 8
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             start,
    input  logic             skip_init,
    input  logic [L_W-1:0]   SEED_l,
    input  logic [N_W-1:0]   SEED_n,
    output logic             busy,
    output logic             running,
    output logic             ks_bit,
    output logic             ks_bit_valid,
    output logic [OUT_W-1:0] out_word,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int RW = (INIT_ROUNDS > 1) ? $clog2(INIT_ROUNDS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN} state_e;

    state_e           state_q, state_d;
    logic [L_W-1:0]   l_q, l_d;
    logic [N_W-1:0]   n_q, n_d;
    logic [RW-1:0]    rnd_q, rnd_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [OUT_W-1:0] col_q, col_d;
    logic [OUT_W-1:0] out_word_q, out_word_d;
    logic             out_valid_q, out_valid_d;

    logic             z, lf, nf, init_fb, stall, run_step, word_done;
    logic [OUT_W-1:0] word_next;

    // Step function on registered state; in INIT the output bit is folded back in.
    assign z       = (^(l_q & ZL_MASK)) ^ (^(n_q & ZN_MASK)) ^ (l_q[ZA] & n_q[ZB]);
    assign init_fb = (state_q == S_INIT) & z;
    assign lf      = (^(l_q & LF_MASK)) ^ init_fb;
    assign nf      = (^(n_q & NF_MASK)) ^ l_q[0] ^ (n_q[NA] & n_q[NB]) ^ init_fb;

    // Only the bit that would complete a word can be blocked by a full output register.
    assign stall     = out_valid_q && !out_ready && (bit_cnt_q == CW'(OUT_W - 1));
    assign run_step  = (state_q == S_RUN) && !stall && !start;
    assign word_done = bit_cnt_q == CW'(OUT_W - 1);
    assign word_next = OUT_W'({col_q, z});

    always_comb begin
        state_d     = state_q;
        l_d         = l_q;
        n_d         = n_q;
        rnd_d       = rnd_q;
        bit_cnt_d   = bit_cnt_q;
        col_d       = col_q;
        out_word_d  = out_word_q;
        out_valid_d = out_valid_q;
        if (start) begin
            // Reload from any state; a pending word and partial collector are discarded.
            l_d         = SEED_l;
            n_d         = SEED_n;
            bit_cnt_d   = '0;
            col_d       = '0;
            out_valid_d = 1'b0;
            rnd_d       = RW'(INIT_ROUNDS - 1);
            state_d     = skip_init ? S_RUN : S_INIT;
        end else begin
            case (state_q)
                S_INIT: begin
                    l_d = {lf, l_q[L_W-1:1]};
                    n_d = {nf, n_q[N_W-1:1]};
                    if (rnd_q == '0) state_d = S_RUN;
                    else             rnd_d   = rnd_q - RW'(1);
                end
                S_RUN: begin
                    if (out_valid_q && out_ready) out_valid_d = 1'b0;
                    if (run_step) begin
                        l_d   = {lf, l_q[L_W-1:1]};
                        n_d   = {nf, n_q[N_W-1:1]};
                        col_d = word_next;
                        if (word_done) begin
                            out_word_d  = word_next;
                            out_valid_d = 1'b1;
                            bit_cnt_d   = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            l_q         <= '0;
            n_q         <= '0;
            rnd_q       <= '0;
            bit_cnt_q   <= '0;
            col_q       <= '0;
            out_word_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            l_q         <= l_d;
            n_q         <= n_d;
            rnd_q       <= rnd_d;
            bit_cnt_q   <= bit_cnt_d;
            col_q       <= col_d;
            out_word_q  <= out_word_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign busy         = (state_q == S_INIT);
    assign running      = (state_q == S_RUN);
    assign ks_bit_valid = run_step;
    assign ks_bit       = run_step & z;
    assign out_word     = out_word_q;
    assign out_valid    = out_valid_q;

endmodule

// File: tb/tb_grain_keystream_gen.sv
// Scoreboarded bench for grain_keystream_gen: a bit-serial reference model fills
// expected-word queues; negedge monitors pop and compare on every accepted word.
module tb_grain_keystream_gen;

    // Tap sets for the reduced instance (L_W=32, N_W=16)
    localparam logic [31:0] B_LF = (32'd1 << 0) | (32'd1 << 7) | (32'd1 << 19) | (32'd1 << 27);
    localparam logic [15:0] B_NF = (16'd1 << 0) | (16'd1 << 4) | (16'd1 << 9) | (16'd1 << 13);
    localparam logic [31:0] B_ZL = (32'd1 << 0) | (32'd1 << 15) | (32'd1 << 30);
    localparam logic [15:0] B_ZN = (16'd1 << 1) | (16'd1 << 8) | (16'd1 << 14);

    logic Clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 Clk = ~Clk;

    logic        start_a = 0, skip_a = 0, ready_a = 0;
    logic [79:0] seed_l_a = '0;
    logic [23:0] seed_n_a = '0;
    logic        busy_a, running_a, ks_a, ksv_a, valid_a;
    logic [7:0]  word_a;

    logic        start_b = 0, skip_b = 0, ready_b = 0;
    logic [31:0] seed_l_b = '0;
    logic [15:0] seed_n_b = '0;
    logic        busy_b, running_b, ks_b, ksv_b, valid_b;
    logic [3:0]  word_b;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];

    grain_keystream_gen dut_a (
        .Clk(Clk), .reset(rst_n), .start(start_a), .skip_init(skip_a),
        .SEED_l(seed_l_a), .SEED_n(seed_n_a), .busy(busy_a), .running(running_a),
        .ks_bit(ks_a), .ks_bit_valid(ksv_a), .out_word(word_a), .out_valid(valid_a),
        .out_ready(ready_a)
    );

    grain_keystream_gen #(
        .L_W(32), .N_W(16), .LF_MASK(B_LF), .NF_MASK(B_NF), .NA(2), .NB(11),
        .ZL_MASK(B_ZL), .ZN_MASK(B_ZN), .ZA(21), .ZB(6), .INIT_ROUNDS(1), .OUT_W(4)
    ) dut_b (
        .Clk(Clk), .reset(rst_n), .start(start_b), .skip_init(skip_b),
        .SEED_l(seed_l_b), .SEED_n(seed_n_b), .busy(busy_b), .running(running_b),
        .ks_bit(ks_b), .ks_bit_valid(ksv_b), .out_word(word_b), .out_valid(valid_b),
        .out_ready(ready_b)
    );

    // Reference step, written bit by bit from the tap positions.
    task automatic mstep(input int sel, input bit init, inout logic [79:0] l,
                         inout logic [23:0] n, output bit z);
        int lw, nw, na, nb, za, zb;
        logic [79:0] lfm, zlm;
        logic [23:0] nfm, znm;
        bit lf, nf;
        if (sel == 0) begin
            lw = 80; nw = 24; na = 3; nb = 17; za = 46; zb = 12;
            lfm = '0; zlm = '0; nfm = '0; znm = '0;
            lfm[0] = 1; lfm[13] = 1; lfm[23] = 1; lfm[38] = 1; lfm[51] = 1; lfm[62] = 1;
            nfm[0] = 1; nfm[5] = 1; nfm[9] = 1; nfm[14] = 1; nfm[20] = 1;
            zlm[0] = 1; zlm[25] = 1; zlm[64] = 1;
            znm[1] = 1; znm[10] = 1; znm[22] = 1;
        end else begin
            lw = 32; nw = 16; na = 2; nb = 11; za = 21; zb = 6;
            lfm = '0; zlm = '0; nfm = '0; znm = '0;
            lfm[0] = 1; lfm[7] = 1; lfm[19] = 1; lfm[27] = 1;
            nfm[0] = 1; nfm[4] = 1; nfm[9] = 1; nfm[13] = 1;
            zlm[0] = 1; zlm[15] = 1; zlm[30] = 1;
            znm[1] = 1; znm[8] = 1; znm[14] = 1;
        end
        z = l[za] & n[zb];
        for (int i = 0; i < lw; i++) if (zlm[i]) z ^= l[i];
        for (int i = 0; i < nw; i++) if (znm[i]) z ^= n[i];
        lf = 0;
        for (int i = 0; i < lw; i++) if (lfm[i]) lf ^= l[i];
        nf = l[0] ^ (n[na] & n[nb]);
        for (int i = 0; i < nw; i++) if (nfm[i]) nf ^= n[i];
        if (init) begin lf ^= z; nf ^= z; end
        l = l >> 1; l[lw-1] = lf;
        n = n >> 1; n[nw-1] = nf;
    endtask

    task automatic push_exp(input int sel, input logic [79:0] ls, input logic [23:0] ns,
                            input bit skip, input int nwords);
        logic [79:0] l;
        logic [23:0] n;
        logic [7:0]  w;
        bit z;
        int rounds, ow;
        l = ls; n = ns;
        rounds = (sel == 0) ? 160 : 1;
        ow     = (sel == 0) ? 8 : 4;
        if (!skip) for (int r = 0; r < rounds; r++) mstep(sel, 1'b1, l, n, z);
        for (int k = 0; k < nwords; k++) begin
            w = '0;
            for (int b = 0; b < ow; b++) begin
                mstep(sel, 1'b0, l, n, z);
                w = {w[6:0], z};
            end
            if (sel == 0) qa.push_back(w);
            else          qb.push_back(w);
        end
    endtask

    always @(negedge Clk) begin
        if (rst_n && valid_a && ready_a && qa.size() > 0) begin
            logic [7:0] e;
            e = qa.pop_front();
            vectors++;
            if (word_a !== e) begin
                miscompares++;
                $display("FAIL word_a got %h exp %h", word_a, e);
            end
        end
        if (rst_n && valid_b && ready_b && qb.size() > 0) begin
            logic [7:0] e;
            e = qb.pop_front();
            vectors++;
            if ({4'h0, word_b} !== e) begin
                miscompares++;
                $display("FAIL word_b got %h exp %h", word_b, e[3:0]);
            end
        end
    end

    task automatic pulse_a(input logic [79:0] l, input logic [23:0] n, input bit skip);
        @(posedge Clk); #1;
        start_a = 1; seed_l_a = l; seed_n_a = n; skip_a = skip;
        @(posedge Clk); #1;
        start_a = 0;
    endtask

    task automatic wait_qa(input int bound, output bit ok);
        int c = 0;
        while (qa.size() > 0 && c < bound) begin @(negedge Clk); c++; end
        ok = (qa.size() == 0);
    endtask

    task automatic count_busy_a(output int cnt, output bit entered);
        int c = 0;
        cnt = 0; entered = 0;
        while (c < 400) begin
            @(negedge Clk); c++;
            if (running_a) begin entered = 1; break; end
            if (busy_a) cnt++;
        end
    endtask

    task automatic test_reset;
        int c;
        @(negedge Clk);
        vectors++;
        if ({busy_a, running_a, ks_a, ksv_a, valid_a, word_a, busy_b, running_b, valid_b, word_b} !== '0) begin
            miscompares++;
            $display("FAIL reset_state got a=%b%b%b%b%b %h b=%b%b%b %h exp all 0",
                     busy_a, running_a, ks_a, ksv_a, valid_a, word_a, busy_b, running_b, valid_b, word_b);
        end
        rst_n = 1;
        ready_a = 0;
        pulse_a(80'h0123_4567_89ab_cdef_0f1e, 24'h8c3a51, 1'b1);
        c = 0;
        while (!valid_a && c < 30) begin @(negedge Clk); c++; end
        vectors++;
        if (!(valid_a && running_a)) begin
            miscompares++;
            $display("FAIL reset_precond got valid=%b running=%b exp 1 1", valid_a, running_a);
        end
        @(posedge Clk); #2;
        rst_n = 0;
        #1;
        vectors++;
        if ({busy_a, running_a, ks_a, ksv_a, valid_a, word_a} !== '0) begin
            miscompares++;
            $display("FAIL async_reset got %b%b%b%b%b %h exp 0", busy_a, running_a, ks_a, ksv_a, valid_a, word_a);
        end
        @(negedge Clk); rst_n = 1;
        c = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            if (busy_a || running_a || valid_a || ksv_a) c++;
        end
        vectors++;
        if (c != 0) begin
            miscompares++;
            $display("FAIL idle_hold got %0d active cycles exp 0", c);
        end
    endtask

    task automatic test_zero_init;
        int cnt, k, bad;
        bit entered, ok;
        push_exp(0, '0, '0, 1'b0, 4);
        pulse_a('0, '0, 1'b0);
        ready_a = 1;
        count_busy_a(cnt, entered);
        vectors++;
        if (cnt != 160 || !entered) begin
            miscompares++;
            $display("FAIL zero_busy_len got %0d entered=%b exp 160 1", cnt, entered);
        end
        k = 0; bad = 0;
        while (!valid_a && k < 20) begin
            if (ks_a) bad++;
            @(negedge Clk); k++;
        end
        vectors++;
        if (k != 8) begin
            miscompares++;
            $display("FAIL zero_first_valid got %0d cycles exp 8", k);
        end
        wait_qa(100, ok);
        vectors++;
        if (!ok || bad != 0) begin
            miscompares++;
            $display("FAIL zero_stream got drained=%b nonzero_bits=%0d exp 1 0", ok, bad);
        end
        ready_a = 0;
    endtask

    task automatic test_skip_init_stream;
        bit ok;
        push_exp(0, 80'h1, 24'h0, 1'b1, 64);
        pulse_a(80'h1, 24'h0, 1'b1);
        ready_a = 1;
        @(negedge Clk);
        vectors++;
        if ({ksv_a, ks_a} !== 2'b11) begin
            miscompares++;
            $display("FAIL skip_first_bit got valid=%b bit=%b exp 1 1", ksv_a, ks_a);
        end
        wait_qa(64 * 8 + 50, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL skip_stream_drain got %0d left exp 0", qa.size());
        end
        ready_a = 0;
    endtask

    task automatic test_backpressure;
        int c, nbits;
        bit chg, ok;
        logic [7:0] w0;
        push_exp(0, 80'ha5a5_0f0f_1234_5678_9abc, 24'h5a5a5a, 1'b1, 12);
        pulse_a(80'ha5a5_0f0f_1234_5678_9abc, 24'h5a5a5a, 1'b1);
        c = 0;
        while (!valid_a && c < 30) begin @(negedge Clk); c++; end
        w0 = word_a; nbits = 0; chg = 0;
        for (int i = 0; i < 20; i++) begin
            if (ksv_a) nbits++;
            if (word_a !== w0 || !valid_a) chg = 1;
            @(negedge Clk);
        end
        vectors++;
        if (nbits != 7) begin
            miscompares++;
            $display("FAIL bp_bits_before_stall got %0d exp 7", nbits);
        end
        vectors++;
        if (chg || c >= 30) begin
            miscompares++;
            $display("FAIL bp_word_stable got changed=%b timeout=%b exp 0 0", chg, c >= 30);
        end
        ready_a = 1;
        wait_qa(200, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL bp_drain got %0d left exp 0", qa.size());
        end
        ready_a = 0;
    endtask

    task automatic test_restart_in_init;
        int cnt;
        bit entered, ok;
        pulse_a(80'hdead_beef_cafe_f00d_1357, 24'h2468ac, 1'b0);
        repeat (50) @(negedge Clk);
        push_exp(0, 80'h114313ecba9118200465, 24'h313ec8, 1'b0, 8);
        pulse_a(80'h114313ecba9118200465, 24'h313ec8, 1'b0);
        ready_a = 1;
        count_busy_a(cnt, entered);
        vectors++;
        if (cnt != 160 || !entered) begin
            miscompares++;
            $display("FAIL restart_busy_len got %0d entered=%b exp 160 1", cnt, entered);
        end
        wait_qa(200, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL restart_drain got %0d left exp 0", qa.size());
        end
        ready_a = 0;
    endtask

    task automatic test_small_params;
        int c, cnt;
        push_exp(1, {48'h0, 32'hdef12345}, {8'h0, 16'h172d}, 1'b0, 16);
        @(posedge Clk); #1;
        start_b = 1; seed_l_b = 32'hdef12345; seed_n_b = 16'h172d; skip_b = 0;
        @(posedge Clk); #1;
        start_b = 0; ready_b = 1;
        c = 0; cnt = 0;
        while (c < 20) begin
            @(negedge Clk); c++;
            if (running_b) break;
            if (busy_b) cnt++;
        end
        vectors++;
        if (cnt != 1 || !running_b) begin
            miscompares++;
            $display("FAIL small_busy_len got %0d running=%b exp 1 1", cnt, running_b);
        end
        c = 0;
        while (qb.size() > 0 && c < 200) begin @(negedge Clk); c++; end
        vectors++;
        if (qb.size() != 0) begin
            miscompares++;
            $display("FAIL small_drain got %0d left exp 0", qb.size());
        end
        ready_b = 0;
    endtask

    initial begin
        test_reset;
        test_zero_init;
        test_skip_init_stream;
        test_backpressure;
        test_restart_in_init;
        test_small_params;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
